// File: rtl/array_fill_pkg.sv
// Shared types and defaults for the array fill controller.
package array_fill_pkg;

   localparam int N_ENTRIES_DEF = 8;
   localparam int N_REQ_DEF     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Index width that stays legal for a single-element range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin winner select with a registered priority pointer.
module rr_arb
   import array_fill_pkg::*;
#(
   parameter int N  = N_REQ_DEF,
   parameter int IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] last,
   output logic          any,
   output logic [IW-1:0] win
);

   logic [IW-1:0] ptr;

   // ptr is the highest-priority index; the last winner becomes lowest.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (last == IW'(N - 1)) ? '0 : last + 1'b1;
      end
   end

   always_comb begin
      int k;
      any = 1'b0;
      win = '0;
      k   = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (!any && req[k]) begin
            any = 1'b1;
            win = IW'(k);
         end
      end
   end

endmodule

// File: rtl/array_fill_ctrl.sv
// Arbitrated serial fill of a bit array with hold-until-ack handoff.
// Optional broadcast load enabled by defining ARRAY_FILL_BCAST_EN.
module array_fill_ctrl
   import array_fill_pkg::*;
#(
   parameter int N_ENTRIES = N_ENTRIES_DEF,
   parameter int N_REQ     = N_REQ_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_data,
`ifdef ARRAY_FILL_BCAST_EN
   input  logic [N_REQ-1:0] i_bcast,
`endif
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_a [0:N_ENTRIES-1],
   output logic             o_valid,
   input  logic             i_ack
);

   localparam int CW = idx_w(N_ENTRIES);
   localparam int IW = idx_w(N_REQ);

   state_e        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] wid;
   logic          any;
   logic [IW-1:0] win;
   logic          wr;
   logic          din;
   logic          last;
   logic          bc;
   logic          rr_en;

   assign wr    = (state == FILL) && o_gnt[wid] && i_req[wid];
   assign din   = i_data[wid];
   assign last  = wr && (cnt == CW'(N_ENTRIES - 1));
   assign rr_en = (state == HOLD) && i_ack;

`ifdef ARRAY_FILL_BCAST_EN
   assign bc = wr && (cnt == '0) && i_bcast[wid];
`else
   assign bc = 1'b0;
`endif

   rr_arb #(
      .N  (N_REQ),
      .IW (IW)
   ) u_arb (
      .clk  (i_clk),
      .rst  (i_rst),
      .req  (i_req),
      .en   (rr_en),
      .last (wid),
      .any  (any),
      .win  (win)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         wid     <= '0;
         o_gnt   <= '0;
         o_valid <= 1'b0;
         for (int k = 0; k < N_ENTRIES; k++) o_a[k] <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  wid   <= win;
                  o_gnt <= N_REQ'(1) << win;
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               if (bc) begin
                  for (int k = 0; k < N_ENTRIES; k++) o_a[k] <= din;
                  o_gnt   <= '0;
                  o_valid <= 1'b1;
                  state   <= HOLD;
               end else if (wr) begin
                  o_a[cnt] <= din;
                  // cnt parks at the last index rather than wrapping.
                  if (last) begin
                     o_gnt   <= '0;
                     o_valid <= 1'b1;
                     state   <= HOLD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (i_ack) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/array_fill_ctrl.md
ARRAY_FILL_CTRL -- requirements
Module: array_fill_ctrl

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, number of entries in the output register array.
REQ-002 SHALL have parameter N_REQ, default 2, number of requesters sharing the array.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_req, input, N_REQ, per-requester write request.
REQ-006 SHALL have port i_data, input, N_REQ, per-requester serial data bit.
REQ-007 SHALL have port o_gnt, output, N_REQ, one-hot grant, registered.
REQ-008 SHALL have port o_a, output, [0:N_ENTRIES-1] unpacked bits, the register array contents.
REQ-009 SHALL have port o_valid, output, 1, array holds a complete burst.
REQ-010 SHALL have port i_ack, input, 1, consumer has taken o_a.

Function
REQ-011 SHALL implement FSM states IDLE, FILL and HOLD.
REQ-012 IDLE: if any i_req bit is high, SHALL select one winner round-robin, drive o_gnt one-hot for it from the next cycle, clear cnt to 0, and enter FILL.
REQ-013 Round-robin SHALL give lowest priority to the last granted requester; after reset, requester 0 has highest priority.
REQ-014 FILL: a write SHALL occur only in cycles where o_gnt[w] and i_req[w] are both high; it stores i_data[w] into o_a[cnt] and increments cnt.
REQ-015 FILL with i_req[w] low SHALL stall: cnt, array and o_gnt are held, with no abort and no regrant.
REQ-016 The write at cnt==N_ENTRIES-1 SHALL move the FSM to HOLD; o_gnt drops to 0 and o_valid rises the following cycle.
REQ-017 HOLD: o_a and o_valid SHALL be held stable until i_ack is high; then the next cycle has o_valid=0, state IDLE, and the round-robin pointer updated.
REQ-018 i_ack outside HOLD SHALL be ignored; i_req in FILL/HOLD from non-winners SHALL be ignored and not queued.
REQ-019 Earliest regrant SHALL be one cycle after leaving HOLD, so minimum burst turnaround is N_ENTRIES+3 cycles.
REQ-020 cnt width SHALL be $clog2(N_ENTRIES) and cnt SHALL never exceed N_ENTRIES-1.

Reset
REQ-021 On i_rst, the block SHALL set state=IDLE, cnt=0, o_gnt=0, o_valid=0, every o_a entry=0, and rr pointer=0.
REQ-022 Reset asserted mid-FILL or mid-HOLD SHALL abort the burst with the same values as REQ-021, effective the next cycle.

Configuration
REQ-023 Macro ARRAY_FILL_BCAST_EN, when defined, SHALL add input i_bcast (N_REQ bits).
REQ-024 With ARRAY_FILL_BCAST_EN, i_bcast[w]&i_req[w] at a FILL cycle with cnt==0 SHALL load i_data[w] into all N_ENTRIES entries in that cycle and go to HOLD.
REQ-025 With ARRAY_FILL_BCAST_EN, i_bcast SHALL be ignored when cnt!=0.
REQ-026 Without ARRAY_FILL_BCAST_EN, there SHALL be no i_bcast port and only serial fill.

Structure
REQ-027 Package array_fill_pkg SHALL hold the state enum, N_ENTRIES_DEF=8, and N_REQ_DEF=2.
REQ-028 Round-robin selection SHALL be sub-module rr_arb, which is combinational winner logic with a registered pointer update on an enable.

Verification
REQ-029 Serial fill: reset; i_req=01; i_data[0]=1,0,1,1,0,0,1,0 -> o_gnt=01 for 8 writes, then o_valid=1 with o_a=1,0,1,1,0,0,1,0; i_ack -> o_valid=0 next cycle.
REQ-030 Contention: i_req=11 held over two bursts -> first grant 01, second grant 10; no overlap of grants.
REQ-031 Stall: drop i_req[w] for 3 cycles after the 4th write -> cnt holds at 4, entries 4..7 unwritten until i_req returns, o_valid 3 cycles later than in REQ-029.
REQ-032 Reset mid-FILL after 5 writes -> next cycle o_a all 0, o_gnt=0, IDLE; rr pointer=0.
REQ-033 HOLD stability: i_ack held low for 20 cycles while i_data toggles -> o_a unchanged, o_valid=1 throughout.
REQ-034 With ARRAY_FILL_BCAST_EN: i_bcast=01, i_data[0]=1 on the first FILL cycle -> all 8 entries =1, o_valid=1 next cycle.
